// File: rtl/regfile_mp_sb.sv
// Integer register file for the pipelined core.
// It has two combinational read ports and two write ports. Port B has priority over port A.
// Optional write-to-read bypass forwards same-cycle write data to the read ports.
// A per-register busy scoreboard is set by issue, cleared by writeback and cleared by flush.
// busy_cnt is a registered count of how many busy bits are set.
module regfile_mp_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            we_a,
   input  logic [AW-1:0]   wa_a,
   input  logic [XLEN-1:0] wd_a,
   input  logic            we_b,
   input  logic [AW-1:0]   wa_b,
   input  logic [XLEN-1:0] wd_b,
   input  logic            issue_vld,
   input  logic [AW-1:0]   issue_rd,
   input  logic            flush,
   output logic [AW:0]     busy_cnt
);

   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [AW:0]      cnt_nxt;
   logic             wr_a_eff;
   logic             wr_b_eff;
   logic             issue_eff;

   // Writes or issues aimed at a hardwired zero register are dropped here.
   always_comb begin
      wr_a_eff  = we_a & ~(ZR & (wa_a == '0));
      wr_b_eff  = we_b & ~(ZR & (wa_b == '0));
      issue_eff = issue_vld & ~(ZR & (issue_rd == '0));
   end

   // Read port 1 mux. Zero register comes first, then the B bypass, then the A bypass, then stored data.
   always_comb begin
      rd1      = regs[rs1_addr];
      rs1_busy = busy[rs1_addr];
      if (BP && wr_a_eff && (wa_a == rs1_addr)) begin
         rd1      = wd_a;
         rs1_busy = 1'b0;
      end
      if (BP && wr_b_eff && (wa_b == rs1_addr)) begin
         rd1      = wd_b;
         rs1_busy = 1'b0;
      end
      if (ZR && (rs1_addr == '0)) begin
         rd1      = '0;
         rs1_busy = 1'b0;
      end
   end

   // Read port 2 mux. It uses the same priority order as port 1.
   always_comb begin
      rd2      = regs[rs2_addr];
      rs2_busy = busy[rs2_addr];
      if (BP && wr_a_eff && (wa_a == rs2_addr)) begin
         rd2      = wd_a;
         rs2_busy = 1'b0;
      end
      if (BP && wr_b_eff && (wa_b == rs2_addr)) begin
         rd2      = wd_b;
         rs2_busy = 1'b0;
      end
      if (ZR && (rs2_addr == '0)) begin
         rd2      = '0;
         rs2_busy = 1'b0;
      end
   end

   // Busy next state. Priority from lowest to highest: hold, write clears, issue sets, flush clears.
   // Alongside this, the population count of the next busy vector is computed.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (wr_a_eff && (wa_a == AW'(r))) busy_nxt[r] = 1'b0;
         if (wr_b_eff && (wa_b == AW'(r))) busy_nxt[r] = 1'b0;
         if (issue_eff && (issue_rd == AW'(r))) busy_nxt[r] = 1'b1;
         if (flush) busy_nxt[r] = 1'b0;
      end
      if (ZR) busy_nxt[0] = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
      end
   end

   // State update. Reset wins over everything. When both ports write the same address, port B lands last.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr_a_eff) regs[wa_a] <= wd_a;
         if (wr_b_eff) regs[wa_b] <= wd_b;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule
